// File: rtl/logic_unit_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_pipe_if
// Brief    : Operand/result handshake bundle for the pipelined logic unit.
// Revision : 1.0 - initial release
// ============================================================================
interface logic_unit_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             ones;
    logic             parity;
    logic [WIDTH-1:0] acc;

    modport master (
        output in_valid, op, a, b, clr, out_ready,
        input  in_ready, out_valid, y, zero, ones, parity, acc
    );

    modport slave (
        input  in_valid, op, a, b, clr, out_ready,
        output in_ready, out_valid, y, zero, ones, parity, acc
    );
endinterface
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_pipe
// Brief    : Two-stage bitwise logic unit with XOR accumulator, result flags
//            and valid/ready flow control on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_pipe #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input wire              clk,
    input wire              rst_n,
    logic_unit_pipe_if.slave bus
);
    localparam logic [2:0] c_op_and     = 3'b000;
    localparam logic [2:0] c_op_or      = 3'b001;
    localparam logic [2:0] c_op_nor     = 3'b010;
    localparam logic [2:0] c_op_inv     = 3'b011;
    localparam logic [2:0] c_op_xor     = 3'b100;
    localparam logic [2:0] c_op_nand    = 3'b101;
    localparam logic [2:0] c_op_acc_ld  = 3'b110;
    localparam logic [2:0] c_op_acc_xor = 3'b111;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_result;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_zero;
    logic             r_ones;
    logic             r_parity;
    logic [WIDTH-1:0] r_acc;

    logic             w_s2_load;
    logic             w_s1_load;
    logic             w_accept;
    logic [WIDTH-1:0] w_result;

    // A stage may advance when it is empty or its successor is taking its
    // contents; this chains the stall back from out_ready to in_ready.
    assign w_s2_load = !r_s2_valid || bus.out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign w_accept  = bus.in_valid && w_s1_load;

    always_comb begin
        w_result = '0;
        case (bus.op)
            c_op_and:     w_result = bus.a & bus.b;
            c_op_or:      w_result = bus.a | bus.b;
            c_op_nor:     w_result = ~(bus.a | bus.b);
            c_op_inv:     w_result = ~bus.a;
            c_op_xor:     w_result = bus.a ^ bus.b;
            c_op_nand:    w_result = ~(bus.a & bus.b);
            c_op_acc_ld:  w_result = bus.a;
            c_op_acc_xor: w_result = bus.a ^ r_acc;
            default:      w_result = '0;
        endcase
    end

    // Clear takes priority over an accumulator op accepted in the same cycle;
    // that op's result has already been formed from the pre-clear value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= ACC_INIT;
        end else if (bus.clr) begin
            r_acc <= ACC_INIT;
        end else if (w_accept && (bus.op == c_op_acc_ld || bus.op == c_op_acc_xor)) begin
            r_acc <= w_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_result <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_result <= w_result;
            end
        end
    end

    // On a bubble only the valid drops; Y and flags keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_y        <= '0;
            r_zero     <= 1'b0;
            r_ones     <= 1'b0;
            r_parity   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_y      <= r_s1_result;
                r_zero   <= (r_s1_result == '0);
                r_ones   <= &r_s1_result;
                r_parity <= ^r_s1_result;
            end
        end
    end

    assign bus.in_ready  = w_s1_load;
    assign bus.out_valid = r_s2_valid;
    assign bus.y         = r_y;
    assign bus.zero      = r_zero;
    assign bus.ones      = r_ones;
    assign bus.parity    = r_parity;
    assign bus.acc       = r_acc;
endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_pipe
// Brief    : Self-checking bench for logic_unit_pipe against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;
    localparam int c_w = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(c_w)) bus ();
    logic_unit_pipe_if #(.WIDTH(8))   bus8 ();

    logic_unit_pipe #(.WIDTH(c_w), .ACC_INIT('0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic_unit_pipe #(.WIDTH(8), .ACC_INIT(8'h00)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    typedef struct {
        logic [c_w-1:0] y;
        int             edge_no;
    } item_t;

    item_t          q[$];
    logic [c_w-1:0] got[$];
    logic [c_w-1:0] model_acc;
    int             edge_no;
    int             errors;
    int             checks;
    logic           last_zero, last_ones, last_parity;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [c_w-1:0] ref_result(input logic [2:0] o, input logic [c_w-1:0] a,
                                                  input logic [c_w-1:0] b, input logic [c_w-1:0] acc);
        case (o)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~(a | b);
            3'd3: return ~a;
            3'd4: return a ^ b;
            3'd5: return ~(a & b);
            3'd6: return a;
            default: return a ^ acc;
        endcase
    endfunction

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic cycle(input bit v, input logic [2:0] o, input logic [c_w-1:0] a,
                         input logic [c_w-1:0] b, input bit c, input bit ordy, output bit accepted);
        bit             exp_ready, exp_ov, do_pop;
        logic [c_w-1:0] res;
        @(negedge clk);
        bus.in_valid  = v;
        bus.op        = o;
        bus.a         = a;
        bus.b         = b;
        bus.clr       = c;
        bus.out_ready = ordy;
        #1;
        exp_ready = (q.size() < 2) || ordy;
        exp_ov    = (q.size() > 0) && (edge_no - q[0].edge_no >= 1);
        check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        check("acc", bus.acc, model_acc);
        if (exp_ov) begin
            check("y", bus.y, q[0].y);
            check("zero", 32'(bus.zero), 32'(q[0].y == '0));
            check("ones", 32'(bus.ones), 32'(q[0].y == {c_w{1'b1}}));
            check("parity", 32'(bus.parity), 32'(^q[0].y));
        end
        accepted = v && exp_ready;
        do_pop   = exp_ov && ordy;
        res      = ref_result(o, a, b, model_acc);
        if (do_pop) begin
            last_zero   = bus.zero;
            last_ones   = bus.ones;
            last_parity = bus.parity;
        end
        @(posedge clk);
        edge_no++;
        if (do_pop) begin
            got.push_back(q[0].y);
            void'(q.pop_front());
        end
        if (accepted) q.push_back('{y: res, edge_no: edge_no});
        if (c) model_acc = '0;
        else if (accepted && o == 3'd6) model_acc = a;
        else if (accepted && o == 3'd7) model_acc = a ^ model_acc;
    endtask

    task automatic issue(input logic [2:0] o, input logic [c_w-1:0] a, input logic [c_w-1:0] b,
                         input bit c, input bit ordy);
        bit acc_ok;
        acc_ok = 1'b0;
        for (int i = 0; i < 20 && !acc_ok; i++) cycle(1'b1, o, a, b, c, ordy, acc_ok);
        if (!acc_ok) check("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        bit dummy;
        for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, '0, '0, 1'b0, 1'b1, dummy);
    endtask

    initial begin
        logic [c_w-1:0] exp6 [6];
        bit             dummy;
        errors = 0; checks = 0; edge_no = 0; model_acc = '0;
        bus.in_valid = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.clr = 0; bus.out_ready = 1;
        bus8.in_valid = 0; bus8.op = 0; bus8.a = 0; bus8.b = 0; bus8.clr = 0; bus8.out_ready = 1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_y", bus.y, 32'd0);
        check("rst_flags", {29'd0, bus.zero, bus.ones, bus.parity}, 32'd0);
        check("rst_acc", bus.acc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Six gate ops back to back.
        got.delete();
        for (int i = 0; i < 6; i++) issue(3'(i), 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 1'b1);
        idle(3);
        exp6 = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h000F_000F, 32'h0F0F_0F0F, 32'h0FF0_0FF0, 32'h0FFF_0FFF};
        check("seq_count", got.size(), 32'd6);
        for (int i = 0; i < 6 && i < got.size(); i++) check("seq_y", got[i], exp6[i]);

        // Flag corner cases.
        got.delete();
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        idle(3);
        check("nor_zero_flags", {29'd0, last_zero, last_ones, last_parity}, 32'b100);
        issue(3'd3, 32'h0, 32'h0, 1'b0, 1'b1);
        idle(3);
        check("inv_ones_flag", 32'(last_ones), 32'd1);
        issue(3'd4, 32'h1, 32'h0, 1'b0, 1'b1);
        idle(3);
        check("xor_parity_flag", 32'(last_parity), 32'd1);

        // Accumulator chain, then a clear colliding with an ACC_XOR.
        got.delete();
        issue(3'd6, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b1);
        issue(3'd7, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0, 1'b1);
        issue(3'd7, 32'h0303_0303, 32'hDEAD_BEEF, 1'b0, 1'b1);
        idle(3);
        check("acc_chain", bus.acc, 32'h0026_446A);
        issue(3'd7, 32'h5, 32'h0, 1'b1, 1'b1);
        idle(3);
        check("acc_cleared", bus.acc, 32'h0);
        check("acc_count", got.size(), 32'd4);
        if (got.size() == 4) begin
            check("acc_y0", got[0], 32'h1234_5678);
            check("acc_y1", got[1], 32'h0325_4769);
            check("acc_y2", got[2], 32'h0026_446A);
            check("acc_y3", got[3], 32'h0026_446F);
        end

        // Backpressure: three ops with the consumer stalled.
        got.delete();
        cycle(1'b1, 3'd4, 32'hAAAA_0001, 32'h0, 1'b0, 1'b0, dummy);
        cycle(1'b1, 3'd4, 32'hAAAA_0002, 32'h0, 1'b0, 1'b0, dummy);
        for (int i = 0; i < 4; i++) cycle(1'b1, 3'd4, 32'hAAAA_0003, 32'h0, 1'b0, 1'b0, dummy);
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("bp_y_held", bus.y, 32'hAAAA_0001);
        issue(3'd4, 32'hAAAA_0003, 32'h0, 1'b0, 1'b1);
        idle(4);
        check("bp_count", got.size(), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++) check("bp_order", got[i], 32'hAAAA_0001 + 32'(i));

        // Asynchronous reset with two ops in flight and a non-initial ACC.
        issue(3'd6, 32'h5A5A_5A5A, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 3'd0, 32'hFFFF_FFFF, 32'h1234_0000, 1'b0, 1'b0, dummy);
        cycle(1'b1, 3'd1, 32'h0000_00FF, 32'h1234_0000, 1'b0, 1'b0, dummy);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_acc", bus.acc, 32'h0);
        check("midrst_y", bus.y, 32'h0);
        q.delete();
        model_acc = '0;
        bus.in_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);

        // Eight-bit instance.
        @(negedge clk);
        bus8.in_valid = 1; bus8.op = 3'd4; bus8.a = 8'hA5; bus8.b = 8'h0F;
        @(negedge clk);
        bus8.in_valid = 0;
        @(negedge clk);
        check("w8_out_valid", 32'(bus8.out_valid), 32'd1);
        check("w8_y", 32'(bus8.y), 32'h0000_00AA);
        check("w8_flags", {29'd0, bus8.zero, bus8.ones, bus8.parity}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom, $urandom,
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7), dummy);
        end
        idle(4);
        check("drain_empty", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit. It is the successor to the fixed 32-bit 2x1 gate cells (NOR/AND/INV/OR).
- Adds XOR/NAND, a running XOR accumulator, result flags, and a valid/ready handshake, so the datapath can issue one logic op per cycle with backpressure.
- Sits beside the ALU in the execute stage. It is also used standalone as a checksum engine.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- ACC_INIT, {WIDTH{1'b0}}, accumulator value after reset and after CLR.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RST  input  1  asynchronous active-low reset.
- IN_VALID  input  1  operand/op presented.
- IN_READY  output  1  unit can accept this cycle.
- OP  input  3  operation select, see Behaviour.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B (ignored for INV, ACC_LD, ACC_XOR).
- CLR  input  1  synchronous accumulator clear, independent of IN_VALID.
- OUT_VALID  output  1  result available.
- OUT_READY  input  1  consumer takes result.
- Y  output  WIDTH  result.
- ZERO  output  1  Y == 0.
- ONES  output  1  Y == all ones.
- PARITY  output  1  XOR reduction of Y.
- ACC  output  WIDTH  current accumulator value.

Behaviour:
- Reset (RST low, asynchronous):
  - stage valids cleared, so OUT_VALID=0 and IN_READY=1.
  - Y=0, ZERO=0, ONES=0, PARITY=0.
  - ACC=ACC_INIT.
  - Reset mid-operation discards all in-flight ops; no output is produced for them.
- OP encoding:
  - 000 AND: A&B
  - 001 OR: A|B
  - 010 NOR: ~(A|B)
  - 011 INV: ~A
  - 100 XOR: A^B
  - 101 NAND: ~(A&B)
  - 110 ACC_LD: result A, ACC<=A
  - 111 ACC_XOR: result A^ACC, ACC<=A^ACC
- Accept: transfer occurs when IN_VALID && IN_READY at a rising edge.
  - Accumulator ops read and update ACC at acceptance, so back-to-back ACC_XOR ops chain with no bubble.
- Pipeline, two register stages:
  - S1 captures the computed result and valid.
  - S2 captures Y and flags (ZERO/ONES/PARITY computed from the S1 result) and drives the outputs.
  - Latency is 2 cycles from accept to OUT_VALID when there is no stall; throughput is 1 op/cycle.
- Output handshake:
  - Result transfers when OUT_VALID && OUT_READY.
  - While OUT_VALID && !OUT_READY, Y/flags/OUT_VALID hold stable.
- Stall/flow:
  - S2 loads when S2 is empty or OUT_READY=1.
  - S1 loads when S1 is empty or S2 is loading.
  - IN_READY = !S1_valid || !S2_valid || OUT_READY. The unit holds at most 2 ops and never drops or duplicates one.
- Bubbles: when S1 is empty and S2 loads, S2 valid becomes 0; Y and flags keep their old values but are don't-care while OUT_VALID=0.
- CLR:
  - At an edge with CLR=1, ACC<=ACC_INIT.
  - If an ACC_LD or ACC_XOR is accepted in the same cycle, its result uses the pre-clear ACC, and CLR wins for the ACC update.
  - CLR does not affect ops already in the pipeline.
- ACC updates only on accepted ACC ops or CLR. Ops 000-101 never touch ACC.
- Width: all ops are bitwise with no carries. PARITY is the reduction over all WIDTH bits.

Test Plan:
- Reset then 6 ops, OUT_READY=1, A=0xF0F0_F0F0, B=0xFF00_FF00, ops AND/OR/NOR/INV/XOR/NAND back-to-back:
  - outputs on cycles 2..7: 0xF000_F000, 0xFFF0_FFF0, 0x000F_000F, 0x0F0F_0F0F, 0x0F F0 0F F0 (0x0FF00FF0), 0x0FFF_0FFF.
  - OUT_VALID high 6 consecutive cycles.
- Flags:
  - NOR A=B=0xFFFF_FFFF gives Y=0, ZERO=1, ONES=0, PARITY=0.
  - INV A=0 gives Y=0xFFFF_FFFF, ONES=1.
  - XOR A=1, B=0 gives PARITY=1.
- Accumulator:
  - ACC_LD A=0x1234_5678, then ACC_XOR A=0x1111_1111, then ACC_XOR A=0x0303_0303.
  - Y sequence: 0x1234_5678, 0x0325_4769, 0x0026_446A; final ACC=0x0026_446A.
  - CLR asserted with a 4th ACC_XOR A=5 gives Y=0x0026_446F and ACC=0.
- Backpressure:
  - Hold OUT_READY=0 while issuing 3 ops: IN_READY drops after 2 accepts; Y stays equal to the first result.
  - Then OUT_READY=1: results emerge in order with no loss or duplicate.
- Mid-operation reset:
  - Pull RST low asynchronously (between edges) with 2 ops in flight.
  - OUT_VALID=0 and ACC=ACC_INIT immediately; no stale result appears after release.
- WIDTH=8 instance: XOR A=0xA5, B=0x0F gives Y=0xAA, PARITY=0, ZERO=0.
